// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  // Default divisor/remainder width; dividend/quotient are twice as wide.
  localparam int DIV_N = 3;
  localparam int DVD_W = 2 * DIV_N;
  localparam int CNT_W = $clog2(DVD_W);

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//
// The partial remainder entering a step is always below the divisor, so it
// fits in N bits.  Shifting in the next dividend bit produces a value that
// needs N+1 bits, and the compare against the divisor is done at that width
// so a shifted value with its top bit set is not mistaken for a small one.
module div_step #(
  parameter int N = 3
) (
  input  logic [N-1:0] r_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_out,
  output logic         q_bit
);

  logic [N:0] t;
  logic [N:0] d_ext;

  // Shift the next dividend bit in and try to subtract the divisor.
  always_comb begin
    t     = {r_in, bit_in};
    d_ext = {1'b0, divisor};
    q_bit = (t >= d_ext);
    // After a successful subtract the result is below the divisor, and when
    // no subtract happens t itself is below the divisor, so N bits suffice.
    if (q_bit) begin
      r_out = N'(t - d_ext);
    end else begin
      r_out = t[N-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, MSB first, valid/ready on both sides.
// A zero divisor short-circuits to an all-ones quotient with div_by_zero set.
import div_pkg::*;

module seq_divider #(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int DW = 2 * N;
  localparam int CW = $clog2(DW);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg,   cnt_next;
  logic [DW-1:0]  dvd_reg,   dvd_next;
  logic [N-1:0]   dvs_reg,   dvs_next;
  // Partial remainder.  It never reaches the divisor, so its (N+1)-th bit is
  // always zero and is not stored; div_step widens it for the compare.
  logic [N-1:0]   r_reg,     r_next;
  logic [DW-1:0]  quot_reg,  quot_next;
  logic [N-1:0]   rem_reg,   rem_next;
  logic           dbz_reg,   dbz_next;

  logic [N-1:0]   step_r;
  logic           step_q;

  div_step #(.N(N)) u_step (
    .r_in    (r_reg),
    .bit_in  (dvd_reg[cnt_reg]),
    .divisor (dvs_reg),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  // Handshake flags come straight from the state so they can never disagree.
  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

  // State register and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      r_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      r_reg     <= r_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    r_next     = r_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            // Capture operands so later input changes cannot disturb them.
            dvd_next   = dividend;
            dvs_next   = divisor;
            r_next     = '0;
            cnt_next   = CW'(DW - 1);
            state_next = CALC;
          end else begin
            // Nothing to iterate: publish the saturated result at once.
            quot_next  = '1;
            rem_next   = '0;
            dbz_next   = 1'b1;
            state_next = DONE;
          end
        end
      end

      CALC: begin
        // in_valid is deliberately ignored here.
        r_next    = step_r;
        quot_next = {quot_reg[DW-2:0], step_q};
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == '0) begin
          rem_next   = step_r;
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end

      DONE: begin
        // Result registers are untouched here, so backpressure holds them.
        // Returning to IDLE first means no accept on the take edge.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (N=3) against hand-computed values.
module tb_seq_divider;

  localparam int N  = 3;
  localparam int DW = 2 * N;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;

  int checks;
  int errors;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction, entered and left on a falling edge with the DUT in IDLE.
  // exp_lat is the number of rising edges after the accept edge until
  // out_valid is seen; stall is the number of extra cycles out_ready stays low.
  task automatic run_div(input logic [DW-1:0] a, input logic [N-1:0] b,
                         input int exp_lat, input int stall, input bit disturb,
                         input string tag);
    logic [DW-1:0] qe;
    logic [N-1:0]  re;
    logic          dz;
    int            lat;
    if (b == '0) begin
      qe = '1;
      re = '0;
      dz = 1'b1;
    end else begin
      qe = a / b;
      re = a % b;
      dz = 1'b0;
    end

    check_val({tag, ".in_ready_pre"}, in_ready, 1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 2) begin
        dividend = ~a;
        divisor  = b + 3'd1;
        in_valid = 1'b1;
      end
      if (disturb && lat == 3) begin
        in_valid = 1'b0;
      end
    end
    check_val({tag, ".latency"}, lat, exp_lat);
    check_val({tag, ".out_valid"}, out_valid, 1);

    for (int i = 0; i <= stall; i++) begin
      check_val({tag, ".quotient"}, quotient, qe);
      check_val({tag, ".remainder"}, remainder, re);
      check_val({tag, ".div_by_zero"}, div_by_zero, dz);
      check_val({tag, ".in_ready_busy"}, in_ready, 0);
      if (i < stall) begin
        @(negedge clk);
        check_val({tag, ".out_valid_hold"}, out_valid, 1);
      end
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, ".out_valid_post"}, out_valid, 0);
    check_val({tag, ".in_ready_post"}, in_ready, 1);
    if (disturb) begin
      @(negedge clk);
      check_val({tag, ".no_second_op"}, out_valid, 0);
      check_val({tag, ".still_idle"}, in_ready, 1);
    end
    $display("txn %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d stall=%0d",
             tag, a, b, quotient, remainder, div_by_zero, lat, stall);
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [N-1:0]  rb;
    int            rs;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #2;
    check_val("reset.in_ready", in_ready, 1);
    check_val("reset.out_valid", out_valid, 0);
    check_val("reset.quotient", quotient, 0);
    check_val("reset.remainder", remainder, 0);
    check_val("reset.div_by_zero", div_by_zero, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(6'd45, 3'd6, 6, 0, 1'b0, "basic_45_6");
    run_div(6'd63, 3'd7, 6, 0, 1'b0, "lim_63_7");
    run_div(6'd63, 3'd1, 6, 0, 1'b0, "lim_63_1");
    run_div(6'd5,  3'd7, 6, 0, 1'b0, "lim_5_7");
    run_div(6'd0,  3'd3, 6, 0, 1'b0, "lim_0_3");
    run_div(6'd20, 3'd0, 0, 0, 1'b0, "zero_20_0");
    run_div(6'd12, 3'd5, 6, 0, 1'b0, "after_zero_12_5");
    run_div(6'd50, 3'd4, 6, 4, 1'b0, "bp_50_4");
    run_div(6'd45, 3'd6, 6, 0, 1'b1, "iso_45_6");

    // Reset on the third CALC cycle of 45/6.
    dividend = 6'd45;
    divisor  = 3'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst.quotient", quotient, 0);
    check_val("midrst.remainder", remainder, 0);
    check_val("midrst.div_by_zero", div_by_zero, 0);
    check_val("midrst.out_valid", out_valid, 0);
    check_val("midrst.in_ready", in_ready, 1);
    $display("txn midrst: 45 / 6 aborted in CALC");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst.no_pulse", out_valid, 0);
    run_div(6'd33, 3'd5, 6, 0, 1'b0, "post_rst_33_5");

    for (int k = 0; k < 1000; k++) begin
      ra = DW'($urandom_range(0, 63));
      rb = N'($urandom_range(0, 7));
      rs = $urandom_range(0, 3);
      run_div(ra, rb, (rb == '0) ? 0 : 6, rs, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's 3-bit array multiplier.
- Takes a 2N-bit dividend (multiplier product width) and an N-bit divisor.
- Returns the 2N-bit quotient and the N-bit remainder.
- Resolves one quotient bit per clock, MSB first; valid/ready handshake on both input and output sides.

Parameters:
- N, 3, divisor and remainder width; dividend and quotient width is 2N.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present on dividend/divisor
- in_ready  output  1  block can accept operands
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- quotient  output  2N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async assert, sync-released by the system):
  - State is IDLE; in_ready=1.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal partial remainder, bit counter and operand registers are cleared.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: at a rising edge where in_valid & in_ready.
  - divisor!=0: latch the operands, clear the partial remainder R (N+1 bits), set counter=2N-1, go to CALC.
  - divisor==0: load quotient=all ones, remainder=0, div_by_zero=1, go straight to DONE. out_valid is high after that one edge.
- CALC step, once per edge:
  - t = {R[N-1:0], dvd[counter]}.
  - If t >= {1'b0, divisor}: R = t - divisor and the quotient bit is 1.
  - Otherwise R = t and the quotient bit is 0.
  - The quotient bit shifts into the quotient LSB.
  - The counter decrements. When the counter is 0 on the step edge, go to DONE; remainder = R[N-1:0] and div_by_zero=0.
- Latency: the accept edge plus 2N step edges. out_valid is high after the 2N-th edge following the accept edge, i.e. 2N cycles (6 for N=3).
- DONE:
  - quotient, remainder and div_by_zero hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - When out_valid & out_ready at an edge, go to IDLE. Output data keep their last values; out_valid=0.
  - A new operand cannot be accepted on the same edge that the result is taken. The minimum issue interval is 2N+2 cycles.
- In CALC, in_valid is ignored; operands already latched are unaffected by input changes.
- Quotient registers are updated only in CALC or on the zero-divisor load; they are never visible as partial values with out_valid=1.
- rst_n low in any state, including mid-CALC: immediate return to IDLE with the reset values above. The in-flight operation is discarded with no out_valid pulse.
- Arithmetic is unsigned only. The max quotient (2^(2N))-1 occurs for divisor=1, so no overflow is possible.
- The comparison uses N+1 bits so that a t with its top bit set is handled correctly.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Localparams for width N, dividend width 2N and counter width $clog2(2N).
- One sub-module: div_step. It is a combinational single restoring iteration:
  - Inputs: R, next dividend bit, divisor.
  - Outputs: new R, quotient bit.
- The top holds the FSM, counter, operand registers and output registers.

Test Plan:
- Basic division: dividend=45, divisor=6 -> out_valid exactly 6 cycles after the accept edge; quotient=7, remainder=3, div_by_zero=0.
- Limits:
  - 63/7 -> q=9, r=0.
  - 63/1 -> q=63, r=0.
  - 5/7 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
- Zero divisor: 20/0 -> out_valid on the cycle after accept; q=63, r=0, div_by_zero=1.
  - The next division, 12/5, must give q=2, r=2 with div_by_zero=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid on 50/4 -> q=12, r=2 stay stable and in_ready=0 throughout.
  - Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Input isolation: change dividend/divisor and pulse in_valid during CALC -> result is unaffected and no second operation starts.
- Reset mid-operation: assert rst_n=0 on the 3rd CALC cycle of 45/6 -> outputs are immediately 0 and in_ready=1.
  - After release, 33/5 gives q=6, r=3.
- Random: 1000 random operands against the reference model q=a/b, r=a%b, with random out_ready stalls.
